fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Fetch-stage PC generator and instruction buffer, directly downstream of the branch/jump execute stage.
- Consumes the execute stage's redirect (ExBjEn/BjPc) and issues sequential instruction-memory requests.
- Tracks in-flight requests and discards stale responses after a redirect.
- Delivers {Pc, PcAdd4, Ins} to decode via a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width; equals $bits(CpuType).
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, max in-flight requests plus buffered entries; also the fetch FIFO depth; must be ≥1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- bj_en  in  1  redirect request (ExBjEn from execute).
- bj_pc  in  XLEN  redirect target (BjPc).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address, word aligned.
- imem_rsp_valid  in  1  in-order response valid; no backpressure.
- imem_rsp_data  in  32  instruction word.
- out_valid  out  1  decode entry valid.
- out_ready  in  1  decode accepts entry.
- out_pc  out  XLEN  PC of entry.
- out_pc_add4  out  XLEN  out_pc+4, modulo 2^XLEN.
- out_ins  out  32  instruction.
- misalign_err  out  1  one-cycle pulse: bj_pc[1:0]!=0 seen.

Behaviour:
- Reset values (async on rst_n low): fetch_pc=RESET_PC, state=BOOT, inflight=0, drop_cnt=0, FIFO empty, misalign_err=0. Hence out_valid=0 and imem_req_valid=0.
- FSM:
  - BOOT→RUN unconditionally after one cycle; no request is issued in BOOT.
  - RUN is permanent until reset; reset mid-operation returns to BOOT and loses all state.
- Request rule:
  - imem_req_valid = (state==RUN) & !bj_en & (inflight + fifo_count < DEPTH).
  - imem_req_addr = fetch_pc.
  - Accept (valid&ready): fetch_pc += 4 (wraps at 2^XLEN); push fetch_pc into the tag FIFO (depth DEPTH).
- inflight counts accepted requests without a response. It increments on accept, decrements on imem_rsp_valid, and both may occur in one cycle (net 0). Width $clog2(DEPTH+1).
- Response, drop_cnt==0: pop tag FIFO; push {tag, imem_rsp_data} into the fetch FIFO. Space is guaranteed by the credit rule.
- Response, drop_cnt>0: pop tag, discard data, drop_cnt-=1.
- Output:
  - out_valid = fetch FIFO non-empty. Fields come from the head entry; out_pc_add4 = head pc + 4.
  - Pop on out_valid & out_ready.
  - Minimum latency from request accept to out_valid is 1 cycle after imem_rsp_valid (registered FIFO write).
- Redirect (bj_en=1, any state after BOOT):
  - fetch_pc <= {bj_pc[XLEN-1:2], 2'b00}.
  - Fetch FIFO flushed; the flush wins over a same-cycle pop or push.
  - drop_cnt <= inflight − imem_rsp_valid. All still-outstanding responses become drops; a response arriving this cycle is discarded directly.
  - No request is issued this cycle.
  - misalign_err <= (bj_pc[1:0]!=0) next cycle, otherwise 0.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time, so it never exceeds inflight.
- bj_en during BOOT: fetch_pc and misalign_err update; drop_cnt stays 0.
- Invariant: drop_cnt ≤ inflight ≤ DEPTH; fifo_count + inflight ≤ DEPTH.
- Response with inflight==0 is illegal; covered by an assertion, no defined behaviour.

Decomposition:
- ZionDataType package:
  - FetchEntryType struct {CpuType Pc; logic [31:0] Ins}.
  - RESET_PC default constant.
  - FeState enum {BOOT, RUN}.
- Sub-module fetch_fifo: parameterised synchronous FIFO (type, depth) with push, pop, flush, count, empty/full. Instantiated twice: PC tags and fetch entries.

Test Plan:
- Reset, imem_req_ready=1, 1-cycle response latency, out_ready=1 → addresses 0x0,0x4,0x8…; out_pc 0x0 with out_ins equal to the data returned; out_pc_add4 0x4.
- out_ready=0 with DEPTH=2 → two entries buffered, imem_req_valid held 0; out_ready=1 → entries drain in order and fetch resumes at 0x8.
- Two requests in flight (0x10, 0x14), bj_en=1 with bj_pc=0x100 → both responses discarded; next out_pc=0x100; imem_req_valid=0 on the redirect cycle.
- Redirect in the same cycle as a response and an out pop → FIFO empty next cycle, drop_cnt=inflight−1, no stale out_valid.
- bj_pc=0x102 → misalign_err pulses for exactly 1 cycle; next fetch address 0x100.
- rst_n asserted while two requests are in flight → outputs at reset values immediately; after release, the first request is at RESET_PC, one cycle after BOOT.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch PC generator and its buffers.
package fetch_pc_unit_pkg;

  localparam int unsigned CPU_W = 32;

  typedef logic [CPU_W-1:0] CpuType;

  localparam CpuType RESET_PC_DEF = 32'h0000_0000;

  // One decoded-ready fetch result: the PC it was fetched from and the word returned.
  typedef struct packed {
    CpuType      Pc;
    logic [31:0] Ins;
  } FetchEntryType;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } FeState;

  // Redirect targets are forced onto a word boundary; the low bits only feed the error pulse.
  function automatic CpuType align_word(input CpuType addr);
    return {addr[CPU_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_fetch_fifo.sv
// Small synchronous FIFO with flush; used for both PC tags and fetched entries.
module fetch_pc_unit_fetch_fifo #(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  T                             wdata_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output T                             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A flush cancels any same-cycle push or pop.
  assign do_push = push_i & ~flush_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~flush_i & ~empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: issues sequential imem requests, tracks them,
// drops stale responses after a redirect and buffers results for decode.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bj_en,
  input  logic [XLEN-1:0] bj_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_add4,
  output logic [31:0]     out_ins,
  output logic            misalign_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  FeState           state_q;
  CpuType           fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             misalign_q;

  logic             req_fire;
  logic             rsp_keep;
  logic [SUM_W-1:0] credit_used;

  CpuType           tag_head;
  logic [CNT_W-1:0] tag_cnt;
  logic             tag_empty;
  logic             tag_full;

  FetchEntryType    fe_wdata;
  FetchEntryType    fe_head;
  logic [CNT_W-1:0] fe_cnt;
  logic             fe_empty;
  logic             fe_full;

  // Credit: in-flight requests plus buffered entries may never exceed DEPTH,
  // which guarantees every kept response has a free fetch-FIFO slot.
  assign credit_used    = {1'b0, inflight_q} + {1'b0, fe_cnt};
  assign imem_req_valid = (state_q == RUN) & ~bj_en & (credit_used < SUM_W'(DEPTH));
  assign imem_req_addr  = XLEN'(fetch_pc_q);
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response is kept only when nothing older is pending a drop and no redirect is in progress.
  assign rsp_keep = imem_rsp_valid & ~bj_en & (drop_cnt_q == '0);
  assign fe_wdata = '{Pc: tag_head, Ins: imem_rsp_data};

  assign out_valid    = ~fe_empty;
  assign out_pc       = XLEN'(fe_head.Pc);
  assign out_pc_add4  = XLEN'(fe_head.Pc + CPU_W'(4));
  assign out_ins      = fe_head.Ins;
  assign misalign_err = misalign_q;

  // BOOT lasts exactly one cycle after reset; RUN holds until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= RUN;
  end

  // Next fetch PC, outstanding-request count and stale-response drop count.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    drop_cnt_d = drop_cnt_q;
    if (bj_en) begin
      fetch_pc_d = align_word(CPU_W'(bj_pc));
      if (state_q == RUN) drop_cnt_d = inflight_q - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + CPU_W'(4);
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= CPU_W'(RESET_PC);
      inflight_q <= '0;
      drop_cnt_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      misalign_q <= bj_en & (bj_pc[1:0] != 2'b00);
    end
  end

  // PC of each outstanding request, consumed in order as responses return.
  fetch_pc_unit_fetch_fifo #(
    .T     (CpuType),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_fire),
    .wdata_i (fetch_pc_q),
    .pop_i   (imem_rsp_valid),
    .flush_i (1'b0),
    .rdata_o (tag_head),
    .count_o (tag_cnt),
    .empty_o (tag_empty),
    .full_o  (tag_full)
  );

  // Completed fetches waiting for decode; flushed on redirect.
  fetch_pc_unit_fetch_fifo #(
    .T     (FetchEntryType),
    .DEPTH (DEPTH)
  ) u_entry_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rsp_keep),
    .wdata_i (fe_wdata),
    .pop_i   (out_valid & out_ready),
    .flush_i (bj_en),
    .rdata_o (fe_head),
    .count_o (fe_cnt),
    .empty_o (fe_empty),
    .full_o  (fe_full)
  );

  // Structural invariants of the credit and drop bookkeeping.
  a_rsp_has_inflight: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (inflight_q != '0) && !tag_empty);
  a_tag_tracks_inflight: assert property (@(posedge clk) disable iff (!rst_n)
    tag_cnt == inflight_q);
  a_drop_le_inflight: assert property (@(posedge clk) disable iff (!rst_n)
    drop_cnt_q <= inflight_q);
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    credit_used <= SUM_W'(DEPTH));
  a_no_tag_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(req_fire && tag_full));
  a_no_entry_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_keep && fe_full && !(out_valid && out_ready)));

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit with an in-order imem model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bj_en;
  logic [31:0] bj_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_add4;
  logic [31:0] out_ins;
  logic        misalign_err;

  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;

  exp_t        exp_q[$];
  mem_t        mem_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_due = 0;
  logic [31:0] ref_pc;
  logic        exp_mis;

  fetch_pc_unit #(
    .XLEN     (32),
    .RESET_PC (RESET_PC),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bj_en          (bj_en),
    .bj_pc          (bj_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_pc_add4    (out_pc_add4),
    .out_ins        (out_ins),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs after the edge, sample settled outputs, update the model.
  task automatic step(input logic bj, input logic [31:0] bpc, input int rdy_pct,
                      input logic ordy, input int lat);
    exp_t e;
    int   due;
    @(posedge clk);
    #1;
    cyc++;
    check_eq("misalign_err", 32'(misalign_err), 32'(exp_mis));
    bj_en          = bj;
    bj_pc          = bpc;
    out_ready      = ordy;
    imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    if (exp_q.size() == 0) begin
      check_eq("stale_out_valid", 32'(out_valid), 32'd0);
    end else if (out_valid && out_ready) begin
      e = exp_q.pop_front();
      check_eq("out_pc", out_pc, e.pc);
      check_eq("out_pc_add4", out_pc_add4, e.pc + 32'd4);
      check_eq("out_ins", out_ins, e.ins);
    end
    if (bj) begin
      check_eq("req_on_redirect", 32'(imem_req_valid), 32'd0);
      exp_q.delete();
      ref_pc = {bpc[31:2], 2'b00};
    end else if (imem_req_valid && imem_req_ready) begin
      check_eq("req_addr", imem_req_addr, ref_pc);
      exp_q.push_back('{pc: ref_pc, ins: mem_data(ref_pc)});
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: ref_pc, due: due});
      ref_pc += 32'd4;
    end
    exp_mis = bj & (bpc[1:0] != 2'b00);
  endtask

  // Asynchronous reset in mid-cycle, then release between edges.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_misalign", 32'(misalign_err), 32'd0);
    bj_en          = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;
    exp_q.delete();
    mem_q.delete();
    last_due = cyc;
    ref_pc   = RESET_PC;
    exp_mis  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("boot_no_req", 32'(imem_req_valid), 32'd0);
  endtask

  initial begin : main
    logic [31:0] rpc;
    int          sel;
    bj_en = 1'b0; bj_pc = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; out_ready = 1'b0; ref_pc = RESET_PC; exp_mis = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_misalign", 32'(misalign_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("boot_no_req", 32'(imem_req_valid), 32'd0);

    // Streaming from RESET_PC with single-cycle memory.
    step(1'b0, '0, 100, 1'b1, 1);
    check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
    repeat (11) step(1'b0, '0, 100, 1'b1, 1);

    // Decode stalls: buffer fills, requests stop, then drain in order.
    repeat (8) step(1'b0, '0, 100, 1'b0, 1);
    check_eq("stall_req_hold", 32'(imem_req_valid), 32'd0);
    check_eq("stall_buffered", 32'(out_valid), 32'd1);
    repeat (8) step(1'b0, '0, 100, 1'b1, 1);

    // Two requests outstanding on slow memory, then redirect to 0x100.
    step(1'b1, 32'h0000_0010, 100, 1'b1, 3);
    repeat (3) step(1'b0, '0, 100, 1'b1, 3);
    step(1'b1, 32'h0000_0100, 100, 1'b1, 3);
    repeat (12) step(1'b0, '0, 100, 1'b1, 3);

    // Redirect during steady streaming: response, pop and flush coincide.
    repeat (6) step(1'b0, '0, 100, 1'b1, 1);
    step(1'b1, 32'h0000_0200, 100, 1'b1, 1);
    step(1'b0, '0, 100, 1'b1, 1);
    check_eq("flush_no_stale", 32'(out_valid), 32'd0);
    repeat (6) step(1'b0, '0, 100, 1'b1, 1);

    // Misaligned target: one-cycle pulse, fetch continues at the aligned word.
    step(1'b1, 32'h0000_0102, 100, 1'b1, 1);
    step(1'b0, '0, 100, 1'b1, 1);
    check_eq("misalign_pulse", 32'(misalign_err), 32'd1);
    repeat (6) step(1'b0, '0, 100, 1'b1, 1);

    // Address wrap at the top of the space.
    step(1'b1, 32'hFFFF_FFF8, 100, 1'b1, 1);
    repeat (10) step(1'b0, '0, 100, 1'b1, 1);

    // Reset with requests outstanding.
    repeat (2) step(1'b0, '0, 100, 1'b1, 3);
    do_reset();
    step(1'b0, '0, 100, 1'b1, 1);
    check_eq("post_reset_req", 32'(imem_req_valid), 32'd1);
    repeat (6) step(1'b0, '0, 100, 1'b1, 1);

    // Randomised traffic with occasional redirects.
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(2));
      case (sel)
        0:       rpc = $urandom & 32'h0000_0FFC;
        1:       rpc = $urandom & 32'h0000_0FFF;
        default: rpc = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000F);
      endcase
      step(int'($urandom_range(99)) < 8, rpc, 70,
           int'($urandom_range(99)) < 70, int'($urandom_range(3, 1)));
    end

    // Stop issuing and drain everything owed to decode.
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && mem_q.size() == 0) break;
      step(1'b0, '0, 0, 1'b1, 1);
    end
    check_eq("drain_complete", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
